// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch unit: next-PC select codes, FSM states,
// the NOP used to fill the instruction register, and the default reset PC.
package pc_fetch_unit_pkg;

  localparam int          PC_W             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0,x0,0

  // Next-PC select as produced by the decoder. 010 is unused and falls back to SNPC.
  typedef enum logic [2:0] {
    PCSEL_BEQ  = 3'b000,
    PCSEL_BNE  = 3'b001,
    PCSEL_RSVD = 3'b010,
    PCSEL_JAL  = 3'b011,
    PCSEL_BLT  = 3'b100,
    PCSEL_BGE  = 3'b101,
    PCSEL_JALR = 3'b110,
    PCSEL_SNPC = 3'b111
  } pcsel_e;

  // REQ: request outstanding, WAIT: accepted and awaiting data,
  // HOLD: instruction presented to decode, HALT: misaligned target seen.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Instruction presented to decode together with its own PC.
  typedef struct packed {
    logic [PC_W-1:0] inst;
    logic [PC_W-1:0] pc;
  } inst_pkt_t;

endpackage

// File: rtl/next_pc_calc.sv
// Pure combinational next-PC generation for the committing instruction.
// Also flags a target that is not 4-byte aligned (JALR only clears bit 0).
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = PC_W
) (
  input  logic [2:0]      pc_sel,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;

  // All adders wrap modulo 2^XLEN; carries are intentionally dropped.
  assign pc_plus4    = pc + XLEN'(4);
  assign pc_plus_imm = pc + imm;
  assign jalr_sum    = rs1_val + imm;

  // Select the target; branches fall through to pc+4 when not taken.
  always_comb begin
    target = pc_plus4;
    case (pc_sel)
      PCSEL_BEQ:  target = br_eq  ? pc_plus_imm : pc_plus4;
      PCSEL_BNE:  target = !br_eq ? pc_plus_imm : pc_plus4;
      PCSEL_BLT:  target = br_lt  ? pc_plus_imm : pc_plus4;
      PCSEL_BGE:  target = !br_lt ? pc_plus_imm : pc_plus4;
      PCSEL_JAL:  target = pc_plus_imm;
      PCSEL_JALR: target = {jalr_sum[XLEN-1:1], 1'b0};
      default:    target = pc_plus4;  // SNPC and the reserved code
    endcase
  end

  assign misalign = |target[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch unit: owns the PC, issues one fetch at a time over a
// req/rsp handshake, presents the returned instruction to decode and, on
// commit, advances the PC via next_pc_calc. A misaligned target halts
// fetching until reset.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_vld,
  input  logic            imem_req_rdy,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_vld,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_vld,
  input  logic            inst_rdy,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [2:0]      pc_sel,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic            misalign
);

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [XLEN-1:0] pc;
  inst_pkt_t       held;
  logic            misalign_q;
  logic [XLEN-1:0] target;
  logic            target_misalign;
  logic            rsp_take;
  logic            commit;

  // A response is only meaningful once the request has been accepted; one
  // arriving while still in REQ (same cycle as accept, or left over from
  // before a reset) is dropped here.
  assign rsp_take = (state == ST_WAIT) && imem_rsp_vld;
  assign commit   = (state == ST_HOLD) && inst_rdy;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc (
    .pc_sel   (pc_sel),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .pc       (pc),
    .imm      (imm),
    .rs1_val  (rs1_val),
    .target   (target),
    .misalign (target_misalign)
  );

  // State register; reset from any state returns to issuing a fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_nxt;
  end

  // Next-state: one fetch in flight, one instruction presented at a time.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ:  if (imem_req_rdy) state_nxt = ST_WAIT;
      ST_WAIT: if (imem_rsp_vld) state_nxt = ST_HOLD;
      ST_HOLD: if (inst_rdy)     state_nxt = target_misalign ? ST_HALT : ST_REQ;
      default: state_nxt = ST_HALT;
    endcase
  end

  // Handshake outputs decoded from state; both low in WAIT and HALT.
  always_comb begin
    imem_req_vld = 1'b0;
    inst_vld     = 1'b0;
    case (state)
      ST_REQ:  imem_req_vld = 1'b1;
      ST_HOLD: inst_vld     = 1'b1;
      default: ;
    endcase
  end

  // PC, presented instruction and sticky misalign flag. The PC only moves
  // on commit, so imem_addr is stable for as long as the request is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      held.inst  <= NOP;
      held.pc    <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      if (rsp_take) begin
        held.inst <= imem_rdata;
        held.pc   <= pc;
      end
      if (commit) begin
        pc <= target;
        if (target_misalign) misalign_q <= 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign inst      = held.inst;
  assign inst_pc   = held.pc;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized fetch/commit traffic against a transaction-level PC model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_vld, imem_req_rdy;
  logic [31:0] imem_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rdata;
  logic        inst_vld, inst_rdy;
  logic [31:0] inst, inst_pc;
  logic [2:0]  pc_sel;
  logic        br_eq, br_lt;
  logic [31:0] imm, rs1_val;
  logic        misalign;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mpc;     // model PC of the instruction being fetched next
  bit          halted;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_addr(imem_addr),
    .imem_rsp_vld(imem_rsp_vld), .imem_rdata(imem_rdata),
    .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
    .pc_sel(pc_sel), .br_eq(br_eq), .br_lt(br_lt), .imm(imm), .rs1_val(rs1_val),
    .misalign(misalign)
  );

  initial begin
    #500000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // Memory image: instruction word derived from its address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  // Architectural next-PC rule.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] sel,
                                           input logic eq, input logic lt,
                                           input logic [31:0] im, input logic [31:0] rs);
    case (sel)
      3'b000:  return eq  ? pc + im : pc + 32'd4;
      3'b001:  return !eq ? pc + im : pc + 32'd4;
      3'b100:  return lt  ? pc + im : pc + 32'd4;
      3'b101:  return !lt ? pc + im : pc + 32'd4;
      3'b011:  return pc + im;
      3'b110:  return (rs + im) & 32'hFFFF_FFFE;
      default: return pc + 32'd4;
    endcase
  endfunction

  // Don't-care commit inputs get garbage outside the commit cycle.
  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    pc_sel = r[2:0]; br_eq = r[3]; br_lt = r[4];
    imm = $urandom; rs1_val = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; inst_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; mpc = 32'h0; halted = 1'b0;
    chk("rst_req_vld",  32'(imem_req_vld), 32'd1);
    chk("rst_inst_vld", 32'(inst_vld),     32'd0);
    chk("rst_inst",     inst,              NOP);
    chk("rst_inst_pc",  inst_pc,           32'h0);
    chk("rst_misalign", 32'(misalign),     32'd0);
    chk("rst_addr",     imem_addr,         32'h0);
  endtask

  // Drive one fetch from REQ to HOLD; called at a negedge with DUT in REQ.
  task automatic fetch(input int req_wait, input int rsp_wait, input bit spurious);
    logic [31:0] r;
    chk("req_vld",      32'(imem_req_vld), 32'd1);
    chk("req_addr",     imem_addr,         mpc);
    chk("req_inst_vld", 32'(inst_vld),     32'd0);
    for (int i = 0; i < req_wait; i++) begin
      imem_req_rdy = 1'b0; scramble();
      @(negedge clk);
      chk("req_hold_vld",  32'(imem_req_vld), 32'd1);
      chk("req_hold_addr", imem_addr,         mpc);
    end
    imem_req_rdy = 1'b1;
    if (spurious) begin
      r = $urandom; imem_rsp_vld = 1'b1; imem_rdata = r;
    end
    @(negedge clk);
    imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0;
    chk("wait_req_vld",  32'(imem_req_vld), 32'd0);
    chk("wait_inst_vld", 32'(inst_vld),     32'd0);
    for (int i = 0; i < rsp_wait; i++) begin
      @(negedge clk);
      chk("wait_req_vld",  32'(imem_req_vld), 32'd0);
      chk("wait_inst_vld", 32'(inst_vld),     32'd0);
    end
    imem_rsp_vld = 1'b1; imem_rdata = memf(mpc);
    @(negedge clk);
    imem_rsp_vld = 1'b0; r = $urandom; imem_rdata = r;
    chk("hold_inst_vld", 32'(inst_vld),     32'd1);
    chk("hold_req_vld",  32'(imem_req_vld), 32'd0);
    chk("hold_inst",     inst,              memf(mpc));
    chk("hold_inst_pc",  inst_pc,           mpc);
  endtask

  // Stall in HOLD, then commit with the given controls; updates the model.
  task automatic commit(input int hold_wait, input logic [2:0] sel, input logic eq,
                        input logic lt, input logic [31:0] im, input logic [31:0] rs);
    logic [31:0] t;
    for (int i = 0; i < hold_wait; i++) begin
      inst_rdy = 1'b0; scramble();
      @(negedge clk);
      chk("stall_inst_vld", 32'(inst_vld),     32'd1);
      chk("stall_req_vld",  32'(imem_req_vld), 32'd0);
      chk("stall_inst",     inst,              memf(mpc));
      chk("stall_inst_pc",  inst_pc,           mpc);
    end
    inst_rdy = 1'b1; pc_sel = sel; br_eq = eq; br_lt = lt; imm = im; rs1_val = rs;
    @(negedge clk);
    inst_rdy = 1'b0; scramble();
    t = ref_next(mpc, sel, eq, lt, im, rs);
    mpc = t;
    if (t[1:0] != 2'b00) begin
      halted = 1'b1;
      chk("halt_misalign", 32'(misalign),     32'd1);
      chk("halt_req_vld",  32'(imem_req_vld), 32'd0);
      chk("halt_inst_vld", 32'(inst_vld),     32'd0);
    end else begin
      chk("commit_misalign", 32'(misalign),     32'd0);
      chk("commit_req_vld",  32'(imem_req_vld), 32'd1);
      chk("commit_inst_vld", 32'(inst_vld),     32'd0);
      chk("commit_addr",     imem_addr,         t);
    end
  endtask

  // While halted, nothing the environment does may revive the unit.
  task automatic halt_hold(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      imem_req_rdy = r[0]; imem_rsp_vld = r[1]; inst_rdy = r[2]; imem_rdata = $urandom;
      scramble();
      @(negedge clk);
      chk("halted_req_vld",  32'(imem_req_vld), 32'd0);
      chk("halted_inst_vld", 32'(inst_vld),     32'd0);
      chk("halted_misalign", 32'(misalign),     32'd1);
    end
    imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; inst_rdy = 1'b0;
  endtask

  // Reach an arbitrary PC via a JALR commit.
  task automatic goto_pc(input logic [31:0] a);
    fetch(0, 0, 1'b0);
    commit(0, 3'b110, 1'b0, 1'b0, 32'h0, a);
  endtask

  initial begin
    int c0;
    logic [31:0] r, im, rs;
    rst_n = 1'b0; imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rdata = 32'h0;
    inst_rdy = 1'b0; scramble();
    do_reset();

    // Three sequential commits, zero-wait memory, 3 cycles each.
    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      chk("snpc_addr", imem_addr, 32'(k * 4));
      fetch(0, 0, 1'b0);
      commit(0, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("snpc_cycles", 32'(cyc - c0), 32'd3);
    end
    chk("snpc_addr_final", imem_addr, 32'hC);

    // BEQ taken with negative offset, then not taken.
    goto_pc(32'h100);
    fetch(0, 1, 1'b0);
    commit(0, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("beq_taken", imem_addr, 32'h0F0);
    goto_pc(32'h100);
    fetch(0, 0, 1'b0);
    commit(0, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("beq_not_taken", imem_addr, 32'h104);

    // JALR clears bit 0 without flagging misalign.
    fetch(0, 0, 1'b0);
    commit(0, 3'b110, 1'b0, 1'b0, 32'h4, 32'h2001);
    chk("jalr_addr",     imem_addr,     32'h2004);
    chk("jalr_misalign", 32'(misalign), 32'd0);

    // Wrap of pc+4 at the top of the address space.
    goto_pc(32'hFFFF_FFFC);
    fetch(0, 0, 1'b0);
    commit(0, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // JAL to a misaligned target halts until reset.
    goto_pc(32'h10);
    fetch(0, 0, 1'b0);
    commit(0, 3'b011, 1'b0, 1'b0, 32'h6, 32'h0);
    chk("jal_halt_misalign", 32'(misalign), 32'd1);
    halt_hold(6);
    do_reset();

    // Backpressure on both handshakes: held address, one commit.
    fetch(5, 2, 1'b1);
    commit(4, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("bp_addr", imem_addr, 32'h4);

    // Reset while waiting for data; the late response is dropped.
    goto_pc(32'h40);
    imem_req_rdy = 1'b1;
    @(negedge clk);
    imem_req_rdy = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; imem_rsp_vld = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_vld = 1'b0; mpc = 32'h0; halted = 1'b0;
    chk("rstwait_inst",     inst,              NOP);
    chk("rstwait_inst_pc",  inst_pc,           32'h0);
    chk("rstwait_inst_vld", 32'(inst_vld),     32'd0);
    chk("rstwait_req_vld",  32'(imem_req_vld), 32'd1);
    chk("rstwait_addr",     imem_addr,         32'h0);
    fetch(0, 0, 1'b0);
    commit(0, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      if (halted) begin
        halt_hold(3);
        do_reset();
      end
      r  = $urandom;
      im = $urandom;
      if (r[9:8] != 2'b00) im[1:0] = 2'b00;
      rs = $urandom;
      if (r[11:10] != 2'b00) rs[1:0] = {1'b0, r[14]};
      fetch(int'(r[17:16]), int'(r[19:18]), r[20]);
      commit(int'(r[22:21]), r[2:0], r[3], r[4], im, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
